echo_multi: RTL and testbench
=============================

ECHO_MULTI -- requirements
Module: echo_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 32, echo payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, per-channel FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter NCHAN, default 2, channel count, 1..16; CW = max(1, $clog2(NCHAN)).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req__ENA  input  1  request strobe; a word is accepted only when req__RDY is also high.
REQ-007 SHALL have port req_chan  input  CW  target channel of the request.
REQ-008 SHALL have port req_v  input  WIDTH  request payload.
REQ-009 SHALL have port req__RDY  output  1  high when FIFO[req_chan] is not full; combinational on req_chan.
REQ-010 SHALL have port ind__ENA  output  1  indication valid.
REQ-011 SHALL have port ind_chan  output  CW  channel of the presented word.
REQ-012 SHALL have port ind_v  output  WIDTH  echoed payload.
REQ-013 SHALL have port ind__RDY  input  1  consumer ready; transfer occurs when ind__ENA and ind__RDY are both high.
REQ-014 SHALL have port busy  output  1  high when any FIFO is non-empty.

Function
REQ-015 SHALL keep one FIFO per channel; each FIFO holds DEPTH entries and has a count register of width $clog2(DEPTH+1).
REQ-016 SHALL write req_v into FIFO[req_chan] on a cycle where req__ENA and req__RDY are both high.
REQ-017 SHALL ignore req__ENA while req__RDY is low: no state change, no error flag.
REQ-018 SHALL treat req_chan >= NCHAN as never ready (req__RDY low) and accept no word for it.
REQ-019 SHALL present an accepted word on the indication port no earlier than the cycle after acceptance; there is no same-cycle bypass.
REQ-020 SHALL select the indication channel by round-robin: the first non-empty channel searched upward from pointer rr, wrapping at NCHAN.
REQ-021 SHALL drive ind__ENA, ind_chan and ind_v combinationally from the selected FIFO head; ind__ENA is low when all FIFOs are empty.
REQ-022 SHALL, on a transfer, pop the selected FIFO and set rr to ind_chan+1 (mod NCHAN); rr SHALL hold otherwise.
REQ-023 SHALL hold ind_chan and ind_v stable while ind__ENA is high and ind__RDY is low, unless a lower-priority push changes nothing (a push never alters the selection once presented).
REQ-024 SHALL, on a simultaneous push and pop of the same channel, pop the head and append the new word, leaving the count unchanged; this is legal at full only if req__RDY was high, so a full FIFO accepts no push in that cycle.
REQ-025 SHALL wrap read and write pointers modulo DEPTH and keep per-channel word order FIFO.

Reset
REQ-026 SHALL, while nRST is low at posedge CLK, clear all counts, pointers and rr; this includes a reset mid-transfer, and in-flight data is discarded.
REQ-027 SHALL drive the following during and after reset: ind__ENA=0, busy=0, req__RDY=1 for a valid req_chan; ind_v and ind_chan are don't-care but SHALL be driven as 0 when ind__ENA is low.

Configuration
REQ-028 SHALL, with ECHO_MULTI_COUNT_EN defined, add output echo_count (32 bits) that increments on every indication transfer, wraps at 2^32, and is reset to 0.
REQ-029 SHALL, without ECHO_MULTI_COUNT_EN, have no echo_count port and no counter logic.

Structure
REQ-030 SHALL place the channel-index width function and a shared echo_word_t typedef (WIDTH-parametrised via package parameter default 32) in package echo_pkg.
REQ-031 SHALL implement each channel as an instance of sub-module echo_fifo (params WIDTH, DEPTH; ports CLK, nRST, enq__ENA, enq_v, enq__RDY, deq__ENA, first, first__RDY).

Verification
REQ-032 Single echo: reset, push 22 on ch0, ind__RDY=1 -> the next cycle shows ind__ENA=1, ind_chan=0, ind_v=22; the cycle after, busy=0.
REQ-033 Full/backpressure: ind__RDY=0, push 1..4 on ch1 (DEPTH=4) -> req__RDY low after the 4th push; a 5th ENA is ignored; after releasing ind__RDY, output is 1,2,3,4 in order.
REQ-034 Round-robin: ch0 holds 10,11 and ch1 holds 20,21, ind__RDY=1 -> output order is 10,20,11,21.
REQ-035 Simultaneous push and pop at count 2 on ch0 -> count stays 2 and order is preserved.
REQ-036 Mid-operation reset: 3 words queued, nRST=0 for one cycle -> ind__ENA=0 and busy=0; with ECHO_MULTI_COUNT_EN, echo_count=0.
REQ-037 Invalid channel: NCHAN=3, req_chan=3 with ENA -> req__RDY=0 and no word is ever echoed.

Source files
------------

// File: rtl/echo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | echo_pkg: shared payload type and channel-index width helper         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package echo_pkg;

   parameter int ECHO_WIDTH = 32;

   typedef logic [ECHO_WIDTH-1:0] echo_word_t;

   function automatic int echo_chan_width(input int nchan);
      return (nchan > 1) ? $clog2(nchan) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/echo_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | echo_fifo: single-channel FIFO, DEPTH entries, head visible on first  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module echo_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             enq__ENA,
   input  logic [WIDTH-1:0] enq_v,
   output logic             enq__RDY,
   input  logic             deq__ENA,
   output logic [WIDTH-1:0] first,
   output logic             first__RDY
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_rdptr;
   logic [c_ptr_w-1:0] r_wrptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign enq__RDY   = (r_count != c_full);
   assign first__RDY = (r_count != '0);
   assign first      = first__RDY ? r_mem[r_rdptr] : '0;
   assign w_push     = enq__ENA && enq__RDY;
   assign w_pop      = deq__ENA && first__RDY;

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wrptr] <= enq_v;
      end
   end

   // Push at full is blocked by enq__RDY, so a same-cycle push/pop keeps the count.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_rdptr <= '0;
         r_wrptr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrptr <= r_wrptr + 1'b1;
         end
         if (w_pop) begin
            r_rdptr <= r_rdptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/echo_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | echo_multi: per-channel echo FIFOs drained round-robin to one output  |
// | Rev 1.0 -- ECHO_MULTI_COUNT_EN adds the echo_count transfer counter   |
// +----------------------------------------------------------------------+
module echo_multi
   import echo_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   parameter int  NCHAN = 2,
   localparam int CW    = echo_chan_width(NCHAN)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req__ENA,
   input  logic [CW-1:0]    req_chan,
   input  logic [WIDTH-1:0] req_v,
   output logic             req__RDY,
   output logic             ind__ENA,
   output logic [CW-1:0]    ind_chan,
   output logic [WIDTH-1:0] ind_v,
   input  logic             ind__RDY,
   output logic             busy
`ifdef ECHO_MULTI_COUNT_EN
   ,output logic [31:0]     echo_count
`endif
);

   logic [NCHAN-1:0] w_enq_ena;
   logic [NCHAN-1:0] w_enq_rdy;
   logic [NCHAN-1:0] w_deq_ena;
   logic [NCHAN-1:0] w_nonempty;
   logic [WIDTH-1:0] w_first [NCHAN];
   logic [CW-1:0]    r_rr;
   logic [CW-1:0]    r_hold_chan;
   logic             r_hold;
   logic [CW-1:0]    w_start;
   logic [CW-1:0]    w_sel;
   logic [WIDTH-1:0] w_sel_v;
   logic             w_found;
   logic             w_xfer;
   int               w_idx;

   for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      assign w_enq_ena[gi] = req__ENA && (req_chan == CW'(gi));
      assign w_deq_ena[gi] = w_xfer && (w_sel == CW'(gi));

      echo_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .CLK        (CLK),
         .nRST       (nRST),
         .enq__ENA   (w_enq_ena[gi]),
         .enq_v      (req_v),
         .enq__RDY   (w_enq_rdy[gi]),
         .deq__ENA   (w_deq_ena[gi]),
         .first      (w_first[gi]),
         .first__RDY (w_nonempty[gi])
      );
   end

   // Out-of-range channels match no FIFO and so stay not-ready.
   always_comb begin
      req__RDY = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (req_chan == CW'(i)) begin
            req__RDY = w_enq_rdy[i];
         end
      end
   end

   // A stalled word pins the search start so later pushes cannot steal the slot.
   always_comb begin
      w_start = r_hold ? r_hold_chan : r_rr;
      w_found = 1'b0;
      w_sel   = '0;
      w_sel_v = '0;
      w_idx   = 0;
      for (int k = 0; k < NCHAN; k++) begin
         w_idx = int'(w_start) + k;
         if (w_idx >= NCHAN) begin
            w_idx = w_idx - NCHAN;
         end
         if (!w_found && w_nonempty[w_idx]) begin
            w_found = 1'b1;
            w_sel   = CW'(w_idx);
            w_sel_v = w_first[w_idx];
         end
      end
   end

   assign ind__ENA = w_found;
   assign ind_chan = w_sel;
   assign ind_v    = w_sel_v;
   assign busy     = |w_nonempty;
   assign w_xfer   = w_found && ind__RDY;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_rr        <= '0;
         r_hold      <= 1'b0;
         r_hold_chan <= '0;
      end else begin
         r_hold      <= w_found && !ind__RDY;
         r_hold_chan <= w_sel;
         if (w_xfer) begin
            r_rr <= (w_sel == CW'(NCHAN - 1)) ? '0 : w_sel + 1'b1;
         end
      end
   end

`ifdef ECHO_MULTI_COUNT_EN
   logic [31:0] r_echo_count;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_echo_count <= '0;
      end else if (w_xfer) begin
         r_echo_count <= r_echo_count + 32'd1;
      end
   end

   assign echo_count = r_echo_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_echo_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_echo_multi: directed self-checking bench for echo_multi (NCHAN=3)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_echo_multi;

   localparam int c_width = 32;
   localparam int c_depth = 4;
   localparam int c_nchan = 3;
   localparam int c_cw    = 2;

   logic               CLK = 1'b0;
   logic               nRST;
   logic               req__ENA;
   logic [c_cw-1:0]    req_chan;
   logic [c_width-1:0] req_v;
   logic               req__RDY;
   logic               ind__ENA;
   logic [c_cw-1:0]    ind_chan;
   logic [c_width-1:0] ind_v;
   logic               ind__RDY;
   logic               busy;
`ifdef ECHO_MULTI_COUNT_EN
   logic [31:0]        echo_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   echo_multi #(
      .WIDTH (c_width),
      .DEPTH (c_depth),
      .NCHAN (c_nchan)
   ) u_dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .req__ENA (req__ENA),
      .req_chan (req_chan),
      .req_v    (req_v),
      .req__RDY (req__RDY),
      .ind__ENA (ind__ENA),
      .ind_chan (ind_chan),
      .ind_v    (ind_v),
      .ind__RDY (ind__RDY),
      .busy     (busy)
`ifdef ECHO_MULTI_COUNT_EN
      ,.echo_count (echo_count)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input int ch, input int v);
      req__ENA = 1'b1;
      req_chan = c_cw'(ch);
      req_v    = c_width'(v);
      step();
      req__ENA = 1'b0;
   endtask

   int exp_v [4];
   int exp_c [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST     = 1'b0;
      req__ENA = 1'b0;
      req_chan = '0;
      req_v    = '0;
      ind__RDY = 1'b0;
      step();
      step();
      check("rst_ind_ena", ind__ENA, 0);
      check("rst_busy", busy, 0);
      check("rst_req_rdy", req__RDY, 1);
      nRST = 1'b1;
      #1;
      check("rst_ind_v", ind_v, 0);
      check("rst_ind_chan", ind_chan, 0);

      // single echo, no same-cycle bypass
      ind__RDY = 1'b1;
      req__ENA = 1'b1; req_chan = 2'd0; req_v = 32'd22;
      #1;
      check("no_bypass", ind__ENA, 0);
      step();
      req__ENA = 1'b0;
      #1;
      check("echo_ena", ind__ENA, 1);
      check("echo_chan", ind_chan, 0);
      check("echo_v", ind_v, 22);
      step();
      check("echo_busy", busy, 0);
      check("echo_ena_off", ind__ENA, 0);

      // fill ch1 under backpressure
      ind__RDY = 1'b0;
      for (int i = 1; i <= 4; i++) push(1, i);
      #1;
      check("full_rdy", req__RDY, 0);
      req__ENA = 1'b1; req_chan = 2'd1; req_v = 32'd5;
      step();
      req__ENA = 1'b0;
      #1;
      check("full_hold_v", ind_v, 1);
      ind__RDY = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check("full_ena", ind__ENA, 1);
         check("full_chan", ind_chan, 1);
         check("full_v", ind_v, i);
         step();
      end
      check("full_drained", busy, 0);

      // round-robin between ch0 and ch1
      ind__RDY = 1'b0;
      push(0, 10); push(0, 11); push(1, 20); push(1, 21);
      exp_v = '{10, 20, 11, 21};
      exp_c = '{0, 1, 0, 1};
      ind__RDY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_chan", ind_chan, exp_c[i]);
         check("rr_v", ind_v, exp_v[i]);
         step();
      end
      check("rr_empty", ind__ENA, 0);

      // simultaneous push and pop at count 2
      ind__RDY = 1'b0;
      push(0, 30); push(0, 31);
      ind__RDY = 1'b1;
      req__ENA = 1'b1; req_chan = 2'd0; req_v = 32'd32;
      #1;
      check("pp_rdy", req__RDY, 1);
      check("pp_head", ind_v, 30);
      step();
      req__ENA = 1'b0;
      #1;
      check("pp_v1", ind_v, 31);
      step();
      check("pp_v2", ind_v, 32);
      step();
      check("pp_empty", ind__ENA, 0);

      // a higher-priority push must not displace a presented word
      ind__RDY = 1'b0;
      push(0, 40);
      push(1, 41);
      #1;
      check("hold_chan", ind_chan, 0);
      check("hold_v", ind_v, 40);
      ind__RDY = 1'b1;
      step();
      check("hold_next_chan", ind_chan, 1);
      check("hold_next_v", ind_v, 41);
      step();
`ifdef ECHO_MULTI_COUNT_EN
      check("count_total", echo_count, 14);
`endif

      // reset with words queued
      ind__RDY = 1'b0;
      push(0, 1); push(1, 2); push(2, 3);
      check("pre_rst_busy", busy, 1);
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      #1;
      check("mrst_ena", ind__ENA, 0);
      check("mrst_busy", busy, 0);
      check("mrst_v", ind_v, 0);
`ifdef ECHO_MULTI_COUNT_EN
      check("mrst_count", echo_count, 0);
`endif
      step();
      check("mrst_discard", ind__ENA, 0);

      // invalid channel never accepted
      ind__RDY = 1'b1;
      req__ENA = 1'b1; req_chan = 2'd3; req_v = 32'd99;
      #1;
      check("inv_rdy", req__RDY, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("inv_ena", ind__ENA, 0);
      end
      check("inv_busy", busy, 0);
      req__ENA = 1'b0;
      req_chan = 2'd2;
      #1;
      check("ch2_rdy", req__RDY, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
